icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the fetch stage and the instruction-memory bus.
- Serves the fetch stage's icache_addr/icache_data/icache_rdy handshake combinationally on a hit.
- On a miss, holds icache_rdy low and refills the whole line from memory using a word-wide req/ack bus.
- Supports a global invalidate, used for FENCE.I and for self-modifying-code flushes.

---
 rtl/icache_direct.sv | 82 ++++++++
 tb/tb_icache_direct.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with linear word-by-word line refill
module icache_direct #(
  parameter int LINES = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rst_n,
  input  logic [31:0] icache_addr,
  output logic [31:0] icache_data,
  output logic        icache_rdy,
  input  logic        icache_inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int OFF = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(LINES);
  localparam int TAG = 30 - OFF - IDX;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nx;
  logic [LINES-1:0] valid;
  logic [TAG-1:0] tags [LINES];
  logic [31:0] data [LINES*LINE_WORDS];
  logic [OFF-1:0] beat;
  logic [IDX-1:0] miss_index;
  logic [TAG-1:0] miss_tag;
  logic inv_pending;
  logic [OFF-1:0] addr_off;
  logic [IDX-1:0] addr_idx;
  logic [TAG-1:0] addr_tag;
  logic hit, miss, fill_ack, done, unused_addr_lsbs;
  assign addr_off = icache_addr[OFF+1:2];
  assign addr_idx = icache_addr[OFF+IDX+1:OFF+2];
  assign addr_tag = icache_addr[31:OFF+IDX+2];
  assign unused_addr_lsbs = ^icache_addr[1:0];
  // an invalidate pulse masks hits in the same cycle it clears the valid bits
  assign hit = state == IDLE && !icache_inv && valid[addr_idx] && tags[addr_idx] == addr_tag;
  assign miss = state == IDLE && !hit && !icache_inv;
  assign fill_ack = state == FILL && mem_ack;
  assign done = fill_ack && beat == OFF'(LINE_WORDS - 1);
  assign icache_rdy = hit;
  assign icache_data = hit ? data[{addr_idx, addr_off}] : 32'h0000_0013;
  always_comb begin
    state_nx = state == IDLE ? (miss ? FILL : IDLE) : (done ? IDLE : FILL);
  end
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state <= IDLE;
      valid <= '0;
      beat <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      inv_pending <= 1'b0;
      miss_index <= '0;
      miss_tag <= '0;
    end else begin
      state <= state_nx;
      inv_pending <= state == FILL && !done && (inv_pending || icache_inv);
      if (icache_inv) valid <= '0;
      if (miss) begin
        miss_tag <= addr_tag;
        miss_index <= addr_idx;
        beat <= '0;
        mem_req <= 1'b1;
        mem_addr <= {icache_addr[31:OFF+2], {(OFF+2){1'b0}}};
      end
      if (fill_ack) begin
        beat <= beat + OFF'(1);
        mem_addr <= mem_addr + 32'd4;
      end
      if (done) begin
        mem_req <= 1'b0;
        valid[miss_index] <= !(inv_pending || icache_inv);
      end
    end
  end
  always_ff @(posedge ctrl_clk) begin
    if (fill_ack) data[{miss_index, beat}] <= mem_rdata;
    if (done) tags[miss_index] <= miss_tag;
  end
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed and randomized fetch traffic against a line-level reference model
module tb_icache_direct;
  logic        ctrl_clk = 1'b0;
  logic        ctrl_rst_n = 1'b0;
  logic [31:0] icache_addr = '0;
  logic [31:0] icache_data;
  logic        icache_rdy;
  logic        icache_inv = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  icache_direct #(.LINES(16), .LINE_WORDS(4)) dut (
    .ctrl_clk(ctrl_clk), .ctrl_rst_n(ctrl_rst_n),
    .icache_addr(icache_addr), .icache_data(icache_data), .icache_rdy(icache_rdy),
    .icache_inv(icache_inv), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_line [16];
  bit m_val [16];
  bit m_busy, m_pend, last_rdy;
  logic [31:0] m_base;
  int m_beats, wcnt, lat;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a & ~32'h3) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
    m_busy = 1'b0;
    m_pend = 1'b0;
    m_beats = 0;
    wcnt = 0;
  endtask

  // one clock: drive, check outputs at the falling edge, advance the model at the rising edge
  task automatic step(input logic [31:0] a, input bit inv, input int gap);
    bit ack, exp_rdy, was_busy;
    int ix;
    ix = int'(a[7:4]);
    ack = m_busy ? (wcnt >= gap - 1) : ($urandom_range(0, 3) == 0);
    exp_rdy = !m_busy && !inv && m_val[ix] && m_line[ix] == (a & ~32'hF);
    icache_addr = a;
    icache_inv = inv;
    mem_ack = ack;
    mem_rdata = (m_busy && ack) ? mem_fn(m_base + 32'(4 * m_beats)) : $urandom;
    @(negedge ctrl_clk);
    last_rdy = icache_rdy;
    chk("rdy", 32'(icache_rdy), 32'(exp_rdy));
    chk("data", icache_data, exp_rdy ? mem_fn(a) : 32'h13);
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) chk("mem_addr", mem_addr, m_base + 32'(4 * m_beats));
    @(posedge ctrl_clk);
    was_busy = m_busy;
    if (m_busy) begin
      if (ack) begin
        m_beats++;
        wcnt = 0;
        if (m_beats == 4) begin
          m_busy = 1'b0;
          m_line[int'(m_base[7:4])] = m_base;
          m_val[int'(m_base[7:4])] = !(m_pend || inv);
          m_pend = 1'b0;
        end
      end else wcnt++;
    end else if (!exp_rdy && !inv) begin
      m_busy = 1'b1;
      m_base = a & ~32'hF;
      m_beats = 0;
      wcnt = 0;
    end
    if (inv) begin
      for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
      if (was_busy && m_busy) m_pend = 1'b1;
    end
    #1;
    icache_inv = 1'b0;
    mem_ack = 1'b0;
  endtask

  // hold one address until it hits; lat = cycles spent with rdy low
  task automatic fetch(input logic [31:0] a, input int gap);
    lat = 0;
    last_rdy = 1'b0;
    while (!last_rdy && lat < 200) begin
      step(a, 1'b0, gap);
      if (!last_rdy) lat++;
    end
  endtask

  initial begin
    model_reset();
    @(negedge ctrl_clk);
    chk("rst_rdy", 32'(icache_rdy), 32'd0);
    chk("rst_data", icache_data, 32'h13);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    @(posedge ctrl_clk);
    #1 ctrl_rst_n = 1'b1;

    fetch(32'h100, 1); chk("cold_lat", lat, 32'd5);
    fetch(32'h104, 1); chk("hit_104", lat, 32'd0);
    fetch(32'h108, 1); chk("hit_108", lat, 32'd0);
    fetch(32'h10C, 1); chk("hit_10c", lat, 32'd0);

    fetch(32'h300, 3); chk("slow_lat", lat, 32'd13);
    for (int i = 0; i < 4; i++) begin
      fetch(32'h300 + 32'(4 * i), 1);
      chk("slow_hit", lat, 32'd0);
    end

    fetch(32'h010, 1); chk("fill_010", lat, 32'd5);
    fetch(32'h000, 1); chk("fill_000", lat, 32'd5);
    fetch(32'h100, 1); chk("evict_100", lat, 32'd5);
    fetch(32'h000, 1); chk("evict_000", lat, 32'd5);
    fetch(32'h010, 1); chk("keep_010", lat, 32'd0);

    repeat (3) step(32'h200, 1'b0, 1);
    fetch(32'h040, 1); chk("redir_lat", lat, 32'd7);
    fetch(32'h200, 1); chk("redir_200", lat, 32'd0);
    fetch(32'h20C, 1); chk("redir_20c", lat, 32'd0);

    step(32'h200, 1'b1, 1);
    fetch(32'h200, 1); chk("inv_200", lat, 32'd5);
    fetch(32'h000, 1); chk("inv_000", lat, 32'd5);

    repeat (2) step(32'h500, 1'b0, 1);
    step(32'h500, 1'b1, 1);
    fetch(32'h500, 1); chk("inv_fill", lat, 32'd7);
    fetch(32'h504, 1); chk("inv_refill", lat, 32'd0);

    repeat (4) step(32'h700, 1'b0, 1);
    step(32'h700, 1'b1, 1);
    fetch(32'h700, 1); chk("inv_last", lat, 32'd5);

    repeat (3) step(32'h600, 1'b0, 1);
    ctrl_rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_rdy", 32'(icache_rdy), 32'd0);
    model_reset();
    @(posedge ctrl_clk);
    #1 ctrl_rst_n = 1'b1;
    fetch(32'h600, 1); chk("arst_refill", lat, 32'd5);
    fetch(32'h100, 1); chk("arst_cold", lat, 32'd5);

    for (int i = 0; i < 600; i++) begin
      step((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3)),
           $urandom_range(0, 29) == 0, $urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
